// File: rtl/hack_rom_loader.sv
// Byte-stream loader for the Hack instruction ROM: parses a length-prefixed word stream
// and writes it to instruction memory while holding the CPU in reset. Optional macro: HACK_ROM_LOADER_CHECKSUM_EN.
module hack_rom_loader #(
  parameter int DEPTH = 32768
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  output logic        o_byte_ready,
  output logic        o_wr_en,
  output logic [14:0] o_wr_addr,
  output logic [15:0] o_wr_data,
  output logic        o_cpu_reset,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error
);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM, DONE, ERROR
  } state_t;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t      state, state_nx;
  logic [7:0]  hi_q;
  logic [15:0] len_q, idx_q;
  logic        accept, restart, len_bad, last_word;
  logic [15:0] len_in;

  assign accept    = i_byte_valid && o_byte_ready;
  assign restart   = i_start && (state == IDLE || state == DONE || state == ERROR);
  assign len_in    = {hi_q, i_byte};
  assign len_bad   = (len_in == 16'd0) || ({1'b0, len_in} > DEPTH_W);
  assign last_word = (idx_q + 16'd1 == len_q);

`ifdef HACK_ROM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;
  always_ff @(posedge i_clk) begin
    if (i_reset || restart) csum_q <= 8'd0;
    else if (accept && state != CSUM) csum_q <= csum_q + i_byte;
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE, ERROR: if (i_start) state_nx = LEN_HI;
      LEN_HI:  if (accept) state_nx = LEN_LO;
      LEN_LO:  if (accept) state_nx = len_bad ? ERROR : DATA_HI;
      DATA_HI: if (accept) state_nx = DATA_LO;
      DATA_LO: if (accept) begin
        if (!last_word) state_nx = DATA_HI;
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
        else            state_nx = CSUM;
`else
        else            state_nx = DONE;
`endif
      end
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
      CSUM:    if (accept) state_nx = (i_byte == csum_q) ? DONE : ERROR;
`endif
      default: state_nx = state;
    endcase
  end

  // Write port registers: strobe lasts one cycle, address/data hold until the next word.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_wr_en   <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
      idx_q     <= '0;
      hi_q      <= '0;
      len_q     <= '0;
    end else begin
      o_wr_en <= 1'b0;
      if (restart) idx_q <= '0;
      if (accept) begin
        case (state)
          LEN_HI, DATA_HI: hi_q <= i_byte;
          LEN_LO:          len_q <= len_in;
          DATA_LO: begin
            o_wr_en   <= 1'b1;
            o_wr_addr <= idx_q[14:0];
            o_wr_data <= {hi_q, i_byte};
            idx_q     <= idx_q + 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    o_byte_ready = (state == LEN_HI) || (state == LEN_LO) || (state == DATA_HI) ||
                   (state == DATA_LO) || (state == CSUM);
    o_busy       = o_byte_ready;
    o_done       = (state == DONE);
    o_error      = (state == ERROR);
    // Hold the CPU through the cycle carrying the final write so it never sees a half-written ROM.
    o_cpu_reset  = (state != DONE) || o_wr_en;
  end

endmodule

// File: tb/tb_hack_rom_loader.sv
// Self-checking bench for hack_rom_loader: a stream-level model predicts writes and final status,
// a per-cycle monitor checks every write strobe against it.
module tb_hack_rom_loader;
  typedef logic [7:0] bq_t[$];
  typedef struct packed { logic [14:0] a; logic [15:0] d; } wr_t;

  logic        i_clk = 1'b0, i_reset = 1'b1, i_start = 1'b0, i_byte_valid = 1'b0;
  logic [7:0]  i_byte = 8'h00;
  logic        o_byte_ready, o_wr_en, o_cpu_reset, o_busy, o_done, o_error;
  logic [14:0] o_wr_addr;
  logic [15:0] o_wr_data;

  int   checks = 0, failures = 0;
  wr_t  exp_q[$];
  wr_t  got[$];
  bit   chk_en = 1'b0;
  logic rst_at_edge = 1'b1;
  logic [14:0] prev_a = '0;
  logic [15:0] prev_d = '0;

  hack_rom_loader #(.DEPTH(32768)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_byte_valid(i_byte_valid),
    .i_byte(i_byte), .o_byte_ready(o_byte_ready), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
    .o_wr_data(o_wr_data), .o_cpu_reset(o_cpu_reset), .o_busy(o_busy), .o_done(o_done),
    .o_error(o_error)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(posedge i_clk) rst_at_edge <= i_reset;

  // Monitor: every strobe must match the next predicted write; otherwise the write port holds.
  always @(negedge i_clk) begin
    if (chk_en) begin
      if (o_wr_en) begin
        got.push_back({o_wr_addr, o_wr_data});
        if (exp_q.size() == 0) check("wr_unexpected", {31'd0, o_wr_en}, 32'd0);
        else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", {17'd0, o_wr_addr}, {17'd0, e.a});
          check("wr_data", {16'd0, o_wr_data}, {16'd0, e.d});
          check("cpu_reset_during_wr", {31'd0, o_cpu_reset}, 32'd1);
        end
      end else if (!rst_at_edge) begin
        check("wr_addr_hold", {17'd0, o_wr_addr}, {17'd0, prev_a});
        check("wr_data_hold", {16'd0, o_wr_data}, {16'd0, prev_d});
      end
      check("done_error_excl", {31'd0, o_done & o_error}, 32'd0);
    end
    prev_a = o_wr_addr;
    prev_d = o_wr_data;
  end

  // Stream model: fills exp_q, returns whether the load must end in error and how many bytes get consumed.
  task automatic model(input bq_t s, output bit err, output int nsend);
    int n;
    logic [7:0] sum;
    n = {s[0], s[1]};
    if (n == 0 || n > 32768) begin
      err = 1'b1; nsend = 2;
      return;
    end
    for (int i = 0; i < n; i++) begin
      wr_t e;
      e.a = 15'(i);
      e.d = {s[2 + 2*i], s[3 + 2*i]};
      exp_q.push_back(e);
    end
    nsend = 2 + 2*n;
    err = 1'b0;
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
    sum = 8'd0;
    for (int i = 0; i < nsend; i++) sum = sum + s[i];
    err = (s[nsend] != sum);
    nsend = nsend + 1;
`else
    sum = 8'd0;
`endif
  endtask

  function automatic bq_t with_cs(input bq_t s);
    bq_t r;
    logic [7:0] sum;
    r = s;
    sum = 8'd0;
    foreach (s[i]) sum = sum + s[i];
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
    r.push_back(sum);
`endif
    return r;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    i_byte_valid = 1'b0;
    i_byte = 8'hEE;
    repeat (gap) @(negedge i_clk);
    i_byte_valid = 1'b1;
    i_byte = b;
    t = 0;
    while (!o_byte_ready && t < 20) begin
      @(negedge i_clk);
      t++;
    end
    if (!o_byte_ready) begin
      check("byte_ready_timeout", {31'd0, o_byte_ready}, 32'd1);
      i_byte_valid = 1'b0;
      return;
    end
    @(negedge i_clk);
    i_byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic run_load(input bq_t s, input int maxgap, output bit err);
    int nsend;
    model(s, err, nsend);
    pulse_start();
    for (int k = 0; k < nsend; k++)
      send_byte(s[k], (maxgap > 0) ? int'($urandom_range(1, maxgap)) : 0);
  endtask

  task automatic finish_status(input bit err, input string tag);
    repeat (2) @(negedge i_clk);
    check({tag, "_writes_pending"}, exp_q.size(), 0);
    check({tag, "_done"}, {31'd0, o_done}, {31'd0, !err});
    check({tag, "_error"}, {31'd0, o_error}, {31'd0, err});
    check({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    check({tag, "_cpu_reset"}, {31'd0, o_cpu_reset}, {31'd0, err});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, o_byte_ready}, 32'd0);
    check({tag, "_wr_en"}, {31'd0, o_wr_en}, 32'd0);
    check({tag, "_wr_addr"}, {17'd0, o_wr_addr}, 32'd0);
    check({tag, "_wr_data"}, {16'd0, o_wr_data}, 32'd0);
    check({tag, "_cpu_reset"}, {31'd0, o_cpu_reset}, 32'd1);
    check({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    check({tag, "_done"}, {31'd0, o_done}, 32'd0);
    check({tag, "_error"}, {31'd0, o_error}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   err;
    bq_t  s;
    wr_t  ref_w[$];

    repeat (2) @(negedge i_clk);
    check_reset_outputs("reset");
    i_reset = 1'b0;
    chk_en = 1'b1;
    @(negedge i_clk);

    // Two-word load, gap-free; the CPU reset must drop exactly one cycle after the last write.
    got.delete();
    run_load(with_cs('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD}), 0, err);
`ifndef HACK_ROM_LOADER_CHECKSUM_EN
    check("last_wr_strobe", {31'd0, o_wr_en}, 32'd1);
    check("last_wr_cpu_reset", {31'd0, o_cpu_reset}, 32'd1);
    @(negedge i_clk);
    check("cpu_reset_fall", {31'd0, o_cpu_reset}, 32'd0);
    check("done_after_last", {31'd0, o_done}, 32'd1);
`endif
    finish_status(err, "two_word");
    check("two_word_err_model", {31'd0, err}, 32'd0);
    check("two_word_count", got.size(), 2);
    if (got.size() == 2) begin
      check("w0_addr", {17'd0, got[0].a}, 32'h0);
      check("w0_data", {16'd0, got[0].d}, 32'h1234);
      check("w1_addr", {17'd0, got[1].a}, 32'h1);
      check("w1_data", {16'd0, got[1].d}, 32'hABCD);
    end
    ref_w = got;

    // Bad lengths: zero and DEPTH+1, each restarted from DONE/ERROR.
    got.delete();
    run_load('{8'h00, 8'h00}, 0, err);
    finish_status(err, "len_zero");
    run_load('{8'h80, 8'h01}, 0, err);
    finish_status(err, "len_over");
    check("len_err_no_writes", got.size(), 0);

    // Length exactly DEPTH is legal: loader must stay busy waiting for data.
    pulse_start();
    send_byte(8'h80, 0);
    send_byte(8'h00, 0);
    @(negedge i_clk);
    check("len_depth_error", {31'd0, o_error}, 32'd0);
    check("len_depth_busy", {31'd0, o_busy}, 32'd1);
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    check_reset_outputs("len_depth_rst");

    // Same two-word stream with random idle gaps must produce identical writes.
    got.delete();
    run_load(with_cs('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD}), 5, err);
    finish_status(err, "gappy");
    check("gappy_count", got.size(), ref_w.size());
    foreach (got[i]) if (i < ref_w.size()) check("gappy_same", got[i], ref_w[i]);

    // Reset after the first word of a 3-word load; reset beats a simultaneous start and byte.
    got.delete();
    pulse_start();
    begin
      wr_t e;
      e.a = 15'd0; e.d = 16'hAABB;
      exp_q.push_back(e);
    end
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    i_reset = 1'b1; i_start = 1'b1; i_byte_valid = 1'b1; i_byte = 8'hCC;
    @(negedge i_clk);
    i_reset = 1'b0; i_start = 1'b0; i_byte_valid = 1'b0;
    check_reset_outputs("mid_rst");
    @(negedge i_clk);
    check("mid_rst_idle_busy", {31'd0, o_busy}, 32'd0);
    check("mid_rst_first_word", got.size(), 1);
    exp_q.delete();
    got.delete();
    run_load(with_cs('{8'h00, 8'h03, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33}), 0, err);
    finish_status(err, "after_rst");
    check("after_rst_count", got.size(), 3);
    foreach (got[i]) check("after_rst_addr", {17'd0, got[i].a}, i);

    // Start pulsed mid-load is ignored; start in DONE begins a fresh load.
    got.delete();
    s = with_cs('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD});
    begin
      int nsend;
      model(s, err, nsend);
      pulse_start();
      for (int k = 0; k < 4; k++) send_byte(s[k], 0);
      pulse_start();
      check("start_in_data_busy", {31'd0, o_busy}, 32'd1);
      for (int k = 4; k < nsend; k++) send_byte(s[k], 0);
    end
    finish_status(err, "start_ignored");
    check("start_ignored_count", got.size(), 2);
    pulse_start();
    check("restart_cpu_reset", {31'd0, o_cpu_reset}, 32'd1);
    check("restart_done_clr", {31'd0, o_done}, 32'd0);
    check("restart_busy", {31'd0, o_busy}, 32'd1);
    run_load(with_cs('{8'h00, 8'h01, 8'h00, 8'h05}), 0, err);
    finish_status(err, "restart_load");

`ifdef HACK_ROM_LOADER_CHECKSUM_EN
    got.delete();
    run_load('{8'h00, 8'h01, 8'h00, 8'h05, 8'h06}, 0, err);
    finish_status(err, "cs_good");
    check("cs_good_err", {31'd0, err}, 32'd0);
    run_load('{8'h00, 8'h01, 8'h00, 8'h05, 8'h07}, 0, err);
    finish_status(err, "cs_bad");
    check("cs_bad_err", {31'd0, err}, 32'd1);
    check("cs_count", got.size(), 2);
    foreach (got[i]) check("cs_word", got[i], {15'd0, 16'h0005});
`endif

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hack_rom_loader.md
HACK_ROM_LOADER -- requirements
Module: hack_rom_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 32768, meaning the number of instruction-memory words accepted (1..32768).
REQ-002 SHALL have port i_clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_reset  input  1  meaning a synchronous, active-high reset.
REQ-004 SHALL have port i_start  input  1  meaning a single-cycle request to begin a load.
REQ-005 SHALL have port i_byte_valid  input  1  meaning i_byte holds a valid stream byte.
REQ-006 SHALL have port i_byte  input  8  meaning the next byte of the load stream.
REQ-007 SHALL have port o_byte_ready  output  1  meaning the loader accepts i_byte this cycle.
REQ-008 SHALL have port o_wr_en  output  1  meaning the instruction-memory write strobe.
REQ-009 SHALL have port o_wr_addr  output  15  meaning the instruction-memory write address.
REQ-010 SHALL have port o_wr_data  output  16  meaning the instruction word to write.
REQ-011 SHALL have port o_cpu_reset  output  1  meaning the CPU reset hold, active-high.
REQ-012 SHALL have port o_busy  output  1  meaning a load is in progress.
REQ-013 SHALL have ports o_done and o_error  output  1 each  meaning a load completed successfully or failed (level).

Function
REQ-014 SHALL treat a byte as accepted only in a cycle where i_byte_valid && o_byte_ready.
REQ-015 SHALL parse the stream as: LEN_HI, LEN_LO (16-bit word count N, big-endian), then N words as high byte then low byte.
REQ-016 SHALL implement states IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM, DONE, ERROR.
REQ-017 SHALL move from IDLE, DONE or ERROR to LEN_HI on i_start; SHALL ignore i_start in all other states.
REQ-018 SHALL advance LEN_HI->LEN_LO->DATA_HI->DATA_LO->DATA_HI on each accepted byte only.
REQ-019 SHALL enter ERROR from LEN_LO when N==0 or N>DEPTH; no write occurs.
REQ-020 SHALL drive o_byte_ready=1 exactly in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CSUM.
REQ-021 SHALL pulse o_wr_en for exactly one cycle, the cycle after each DATA_LO acceptance, with o_wr_data={hi,lo} and o_wr_addr equal to the word index (0 for the first word).
REQ-022 SHALL increment the word index after each write; the index never wraps, because N<=DEPTH.
REQ-023 SHALL leave DATA_LO, after word N-1, to CSUM when CHECKSUM_EN is defined, otherwise to DONE.
REQ-024 SHALL drive o_cpu_reset=1 in every state except DONE; it falls exactly one cycle after the final o_wr_en pulse.
REQ-025 SHALL drive o_busy=1 in LEN_HI through CSUM; o_done=1 only in DONE; o_error=1 only in ERROR.
REQ-026 SHALL hold o_wr_addr and o_wr_data stable when o_wr_en=0.
REQ-027 SHALL restart from LEN_HI on i_start in DONE or ERROR, clearing the index, checksum, o_done and o_error and reasserting o_cpu_reset on the next cycle.

Reset
REQ-028 SHALL, when i_reset=1 at a clock edge, enter IDLE regardless of state, including mid-load.
REQ-029 SHALL, on reset, force o_cpu_reset=1 and o_byte_ready=0, o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_busy=0, o_done=0, o_error=0.
REQ-030 SHALL give i_reset priority over i_start and byte acceptance in the same cycle.

Configuration
REQ-031 SHALL compile, when macro HACK_ROM_LOADER_CHECKSUM_EN is defined, an 8-bit running sum of all accepted bytes (LEN_HI included) and a CSUM state that accepts one byte.
REQ-032 SHALL, with the macro defined, enter DONE if the CSUM byte equals the running sum mod 256, else ERROR; words already written remain written.
REQ-033 SHALL, without the macro, contain no checksum logic and never enter CSUM.

Verification
REQ-034 SHALL pass this scenario: reset, i_start, stream 00 02 12 34 AB CD -> writes 0x1234@0 then 0xABCD@1, o_done=1, and o_cpu_reset falls one cycle after the second write.
REQ-035 SHALL pass this scenario: length 00 00, or length 80 01 with DEPTH=32768 -> ERROR, o_error=1, no o_wr_en pulse, o_cpu_reset=1.
REQ-036 SHALL pass this scenario: i_byte_valid toggled randomly with 1-5 idle cycles -> identical writes to the gap-free case, and no byte accepted twice.
REQ-037 SHALL pass this scenario: i_reset asserted after the first word of a 3-word load -> IDLE on the next cycle with all outputs at reset values; a following i_start and full load write at addresses 0..2.
REQ-038 SHALL pass this scenario with CHECKSUM_EN: stream 00 01 00 05 checksum 06 -> DONE; checksum 07 -> ERROR, with 0x0005@0 written in both cases.
REQ-039 SHALL pass this scenario: i_start pulsed in DATA_HI -> ignored; i_start in DONE -> new load begins and o_cpu_reset=1 the next cycle.
